// File: rtl/vgen_flash_player.sv
// Animated flash video generator: streams cfg_n_frames frames from SPI flash,
// one panel row per flash read, expands RGB888/RGB565 pixels and writes them
// into the hub75 frame-buffer write port with row commits and frame swaps.
module vgen_flash_player #(
  parameter int N_BANKS  = 2,
  parameter int N_ROWS   = 32,
  parameter int N_COLS   = 64,
  parameter int N_PLANES = 8,
  parameter int ADDR_W   = 24,
  localparam int R       = N_BANKS * N_ROWS,
  localparam int ROW_W   = (R > 1) ? $clog2(R) : 1,
  localparam int COL_W   = (N_COLS > 1) ? $clog2(N_COLS) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cfg_en,
  input  logic [ADDR_W-1:0]     cfg_base_addr,
  input  logic [7:0]            cfg_n_frames,
  input  logic                  cfg_fmt,
  input  logic                  cfg_loop,
  input  logic [15:0]           cfg_hold,
  output logic [ADDR_W-1:0]     sr_addr,
  output logic [15:0]           sr_len,
  output logic                  sr_go,
  input  logic                  sr_rdy,
  input  logic [7:0]            sr_data,
  input  logic                  sr_valid,
  output logic [ROW_W-1:0]      fbw_row_addr,
  output logic [COL_W-1:0]      fbw_col_addr,
  output logic [3*N_PLANES-1:0] fbw_data,
  output logic                  fbw_wren,
  output logic                  fbw_row_store,
  output logic                  fbw_row_swap,
  input  logic                  fbw_row_rdy,
  output logic                  frame_swap,
  input  logic                  frame_rdy,
  output logic [7:0]            status_frame,
  output logic                  status_done
);

  typedef enum logic [2:0] {
    S_IDLE, S_REQ, S_DATA, S_STORE, S_FSWAP, S_NEXT, S_DONE
  } state_e;

  state_e                state_q;
  logic [ADDR_W-1:0]     base_q, addr_q, sr_addr_q;
  logic [7:0]            n_frames_q, frame_q;
  logic                  fmt_q, loop_q;
  logic [ROW_W-1:0]      row_q, fbw_row_addr_q;
  logic [COL_W-1:0]      col_q, fbw_col_addr_q;
  logic [1:0]            byte_q;
  logic [15:0]           pix_q, hold_q, sr_len_q;
  logic [3*N_PLANES-1:0] fbw_data_q;
  logic                  sr_go_q, fbw_wren_q, fbw_row_store_q, frame_swap_q, status_done_q;

  // Row size in bytes for the latched format; constants selected, no multiplier.
  logic [15:0] row_bytes;
  logic        last_byte;
  logic [23:0] pixel_in;
  assign row_bytes = fmt_q ? 16'(2 * N_COLS) : 16'(3 * N_COLS);
  assign last_byte = (byte_q == (fmt_q ? 2'd1 : 2'd2));
  // Bytes already shifted in plus the byte arriving now; RGB565 uses the low 16 bits.
  assign pixel_in  = {pix_q, sr_data};

  logic [7:0]            r8, g8, b8;
  logic [3*N_PLANES-1:0] pix_exp;

  // Expand the assembled pixel to 8 bits per channel, then keep the top N_PLANES bits.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    r8 = 8'd0;
    g8 = 8'd0;
    b8 = 8'd0;
    if (fmt_q) begin
      r8 = {pixel_in[15:11], pixel_in[15:13]};
      g8 = {pixel_in[10:5],  pixel_in[10:9]};
      b8 = {pixel_in[4:0],   pixel_in[4:2]};
    end else begin
      {r8, g8, b8} = pixel_in;
    end
    pix_exp = {r8[7 -: N_PLANES], g8[7 -: N_PLANES], b8[7 -: N_PLANES]};
  end

  // Playback sequencer: flash requests, pixel writes, row commits and frame swaps.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    if (rst) begin
      state_q         <= S_IDLE;
      base_q          <= '0;
      addr_q          <= '0;
      n_frames_q      <= 8'd1;
      frame_q         <= 8'd0;
      fmt_q           <= 1'b0;
      loop_q          <= 1'b0;
      row_q           <= '0;
      col_q           <= '0;
      byte_q          <= 2'd0;
      pix_q           <= 16'd0;
      hold_q          <= 16'd0;
      sr_addr_q       <= '0;
      sr_len_q        <= 16'd0;
      sr_go_q         <= 1'b0;
      fbw_row_addr_q  <= '0;
      fbw_col_addr_q  <= '0;
      fbw_data_q      <= '0;
      fbw_wren_q      <= 1'b0;
      fbw_row_store_q <= 1'b0;
      frame_swap_q    <= 1'b0;
      status_done_q   <= 1'b0;
    end else begin
      // Pulses last exactly one cycle unless re-asserted below.
      sr_go_q         <= 1'b0;
      fbw_wren_q      <= 1'b0;
      fbw_row_store_q <= 1'b0;
      frame_swap_q    <= 1'b0;
      if (hold_q != 16'd0) hold_q <= hold_q - 16'd1;

      case (state_q)
        S_IDLE: begin
          status_done_q <= 1'b0;
          if (cfg_en) begin
            base_q     <= cfg_base_addr;
            n_frames_q <= (cfg_n_frames == 8'd0) ? 8'd1 : cfg_n_frames;
            fmt_q      <= cfg_fmt;
            loop_q     <= cfg_loop;
            addr_q     <= cfg_base_addr;
            row_q      <= '0;
            frame_q    <= 8'd0;
            state_q    <= S_REQ;
          end
        end
        S_REQ: begin
          if (sr_rdy) begin
            sr_go_q   <= 1'b1;
            sr_addr_q <= addr_q;
            sr_len_q  <= row_bytes - 16'd1;
            col_q     <= '0;
            byte_q    <= 2'd0;
            state_q   <= S_DATA;
          end
        end
        S_DATA: begin
          if (sr_valid) begin
            pix_q <= pixel_in[15:0];
            if (last_byte) begin
              byte_q         <= 2'd0;
              fbw_wren_q     <= 1'b1;
              fbw_data_q     <= pix_exp;
              fbw_col_addr_q <= col_q;
              fbw_row_addr_q <= row_q;
              col_q          <= col_q + COL_W'(1);
              if (col_q == COL_W'(N_COLS - 1)) state_q <= S_STORE;
            end else begin
              byte_q <= byte_q + 2'd1;
            end
          end
        end
        S_STORE: begin
          if (fbw_row_rdy) begin
            fbw_row_store_q <= 1'b1;
            fbw_row_addr_q  <= row_q;
            addr_q          <= addr_q + ADDR_W'(row_bytes);
            if (row_q == ROW_W'(R - 1)) begin
              state_q <= S_FSWAP;
            end else begin
              row_q   <= row_q + ROW_W'(1);
              state_q <= S_REQ;
            end
          end
        end
        S_FSWAP: begin
          if ((hold_q == 16'd0) && frame_rdy) begin
            frame_swap_q <= 1'b1;
            hold_q       <= cfg_hold;
            state_q      <= S_NEXT;
          end
        end
        S_NEXT: begin
          if (frame_q < n_frames_q - 8'd1) begin
            frame_q <= frame_q + 8'd1;
            row_q   <= '0;
            state_q <= S_REQ;
          end else if (loop_q && cfg_en) begin
            base_q     <= cfg_base_addr;
            n_frames_q <= (cfg_n_frames == 8'd0) ? 8'd1 : cfg_n_frames;
            fmt_q      <= cfg_fmt;
            loop_q     <= cfg_loop;
            addr_q     <= cfg_base_addr;
            frame_q    <= 8'd0;
            row_q      <= '0;
            state_q    <= S_REQ;
          end else if (!loop_q) begin
            status_done_q <= 1'b1;
            state_q       <= S_DONE;
          end else begin
            state_q <= S_IDLE;
          end
        end
        S_DONE: begin
          if (!cfg_en) begin
            status_done_q <= 1'b0;
            state_q       <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign sr_addr       = sr_addr_q;
  assign sr_len        = sr_len_q;
  assign sr_go         = sr_go_q;
  assign fbw_row_addr  = fbw_row_addr_q;
  assign fbw_col_addr  = fbw_col_addr_q;
  assign fbw_data      = fbw_data_q;
  assign fbw_wren      = fbw_wren_q;
  assign fbw_row_store = fbw_row_store_q;
  assign fbw_row_swap  = fbw_row_store_q;
  assign frame_swap    = frame_swap_q;
  assign status_frame  = frame_q;
  assign status_done   = status_done_q;

endmodule

// File: doc/vgen_flash_player.md
Name: vgen_flash_player

Overview:
Parametrised successor to the fixed single-frame flash video generator. It streams an animation of cfg_n_frames frames from SPI flash, one panel row per flash read, into the hub75 frame-buffer write port. It supports RGB888 and RGB565 source formats, loop or one-shot playback, and a minimum frame hold time. It sits between spi_flash_reader and hub75_top, in the slot vgen occupies today.

Parameters:
N_BANKS, 2, panel banks; total rows R = N_BANKS*N_ROWS
N_ROWS, 32, rows per bank
N_COLS, 64, columns per row
N_PLANES, 8, bits per channel on fbw_data (1..8)
ADDR_W, 24, flash address width

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
cfg_en  in  1  playback enable
cfg_base_addr  in  ADDR_W  flash byte address of frame 0 row 0
cfg_n_frames  in  8  frame count (0 treated as 1)
cfg_fmt  in  1  0=RGB888 (3 B/px), 1=RGB565 (2 B/px, big-endian)
cfg_loop  in  1  1=wrap to frame 0, 0=stop after last frame
cfg_hold  in  16  minimum clk cycles between frame_swap pulses
sr_addr  out  ADDR_W  flash read address
sr_len  out  16  bytes-1 of read
sr_go  out  1  read request pulse
sr_rdy  in  1  reader idle
sr_data  in  8  read byte
sr_valid  in  1  byte strobe
fbw_row_addr  out  log2(R)  {bank,row} being written
fbw_col_addr  out  log2(N_COLS)  pixel column
fbw_data  out  3*N_PLANES  {R,G,B}, R in MSBs
fbw_wren  out  1  pixel write strobe
fbw_row_store  out  1  commit row pulse
fbw_row_swap  out  1  line-buffer swap pulse (same cycle as store)
fbw_row_rdy  in  1  store may be accepted
frame_swap  out  1  frame swap pulse
frame_rdy  in  1  swap may be accepted
status_frame  out  8  frame index being loaded
status_done  out  1  one-shot playback finished

Behaviour:
- Reset: state IDLE; all pulse outputs 0; sr_addr/sr_len/fbw_* 0; status_frame 0; status_done 0; hold counter expired.
- Config (base, n_frames, fmt, loop) is latched on leaving IDLE and again at every loop wrap. bpp = fmt ? 2 : 3; row_bytes = N_COLS*bpp.
- IDLE: if cfg_en=1, latch config, set the address register to base, and go REQ.
- REQ: wait for sr_rdy=1. Then assert sr_go for exactly one cycle with sr_addr = address register and sr_len = row_bytes-1. Go DATA.
- DATA:
  - Each sr_valid advances a byte index 0..bpp-1 and shifts the byte into a pixel register.
  - On the last byte of a pixel, assert fbw_wren for one cycle, next cycle, with the current col and the expanded data; col then increments.
  - After the write of col N_COLS-1, go STORE.
  - sr_valid outside DATA is ignored.
- Expansion:
  - 888: take the top N_PLANES bits of each byte.
  - 565: R8={r5,r5[4:2]}, G8={g6,g6[5:4]}, B8={b5,b5[4:2]}, then take the top N_PLANES bits of each.
- STORE: wait for fbw_row_rdy=1. Pulse fbw_row_store and fbw_row_swap together for one cycle. Add row_bytes to the address register; no multiplier is used. If row < R-1: row++ and go REQ. Otherwise go FSWAP.
- FSWAP:
  - Wait until the hold counter has expired and frame_rdy=1.
  - Pulse frame_swap for one cycle and reload the hold counter with cfg_hold. The counter decrements every cycle and is expired at 0.
  - Then go NEXT.
- NEXT:
  - If frame < n_frames-1: frame++, row=0, address continues, go REQ.
  - Else if loop=1 and cfg_en=1: frame=0, re-latch config, address=base, go REQ.
  - Else if loop=0: status_done=1, go DONE.
  - Else (loop=1, cfg_en=0): go IDLE.
- cfg_en is sampled only in IDLE and NEXT; dropping it mid-frame still completes the frame.
- DONE: outputs idle. Leave to IDLE (status_done cleared) only when cfg_en=0.
- Address arithmetic is modulo 2^ADDR_W; wrap is silent.
- Simultaneous events:
  - A byte may arrive in the same cycle as the preceding fbw_wren; no bytes are lost, and pixel assembly is pipelined by one register.
  - frame_rdy and hold expiry coincident with FSWAP entry: the swap fires on the entry cycle+1.
- Reset mid-operation, any state: return to IDLE next cycle, with no further sr_go, wren, store or swap pulses.

Test Plan:
- N_BANKS=1, N_ROWS=2, N_COLS=4, fmt=888, base=0x100000, n_frames=1, loop=0 -> sr_go twice with sr_addr 0x100000 then 0x10000C, sr_len=11; 8 wrens; 2 store+swap pairs; 1 frame_swap; status_done=1.
- fmt=565, bytes 0xF8,0x1F -> R=0xFF, G=0x00, B=0xFF; sr_len=7 per row.
- n_frames=3, loop=1 -> status_frame sequence 0,1,2,0; the fourth frame's first sr_addr equals base.
- cfg_hold=1000 with frame_rdy held 1 -> consecutive frame_swap pulses at least 1000 cycles apart.
- fbw_row_rdy held 0 for 50 cycles at STORE -> no store pulse until it rises; store fires the following cycle.
- Assert rst during DATA after 5 bytes -> next cycle IDLE, all outputs 0; restart reproduces frame 0 row 0 address.
